// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the SPI flash responder.
package spi_flash_pkg;

  // Supported flash opcodes
  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_RDID      = 8'h9F;
  localparam logic [7:0] CMD_RDSR      = 8'h05;

  // Number of sclk rises skipped between address and data on FAST READ
  localparam int DUMMY_CYCLES = 8;

  // Responder FSM states (explicit encodings keep waveforms readable)
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_DATA   = 3'd4,
    ST_ID     = 3'd5,
    ST_STAT   = 3'd6,
    ST_IGNORE = 3'd7
  } spi_flash_state_t;

  // Select byte idx of the 3-byte JEDEC ID, MSB byte first; 0x00 past the end
  function automatic logic [7:0] jedec_byte(input logic [23:0] id,
                                            input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = id[23:16];
      2'd1:    b = id[15:8];
      2'd2:    b = id[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, followed by an edge
// detector producing single-cycle rise/fall pulses in the clk domain.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  // Shift the raw pin through the synchronizer chain and remember last level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash slave model: oversamples the master's pins with clk,
// decodes READ / FAST READ / READ ID / READ STATUS and streams bytes from a
// byte-wide backing memory with one cycle of read latency.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | cs_n high, waiting for chip select
// ST_CMD    | shifting in the 8-bit opcode
// ST_ADDR   | shifting in the 24-bit address (low MEM_AW bits kept)
// ST_DUMMY  | FAST READ dummy clocks, mosi ignored
// ST_DATA   | streaming memory bytes, address auto-increments and wraps
// ST_ID     | returning JEDEC ID bytes, then 0x00
// ST_STAT   | returning status 0x00 (never busy, WEL clear)
// ST_IGNORE | unsupported opcode, miso held low until cs_n rises
module spi_flash_responder #(
  parameter int          MEM_AW      = 17,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4017,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_mem_rd,
  output logic [MEM_AW-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_busy,
  output logic              o_bad_cmd
);

  import spi_flash_pkg::*;

  localparam logic [MEM_AW-1:0] ADDR_INC = {{(MEM_AW-1){1'b0}}, 1'b1};
  localparam logic [4:0]        DUMMY_LAST = 5'(DUMMY_CYCLES - 1);

  spi_flash_state_t state;

  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_rise;
  logic                   cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;

  logic [4:0]             bit_cnt;
  logic [6:0]             cmd_shift;
  logic [7:0]             opcode;
  logic                   fast;
  logic                   rd_pending;
  logic [7:0]             prefetch;
  logic [6:0]             tx_shift;
  logic [1:0]             id_idx;
  logic [7:0]             next_byte;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_sclk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (i_sclk),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  // cs_n idles high, so its chain resets high to avoid a spurious edge
  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b1)
  ) u_cs_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (i_cs_n),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  // mosi gets the same depth as sclk so a sampled bit lines up with its rise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mosi_sync <= '0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
    end
  end

  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign opcode = {cmd_shift, mosi_s};

  // Byte presented at the next byte boundary on miso, chosen by state
  always_comb begin
    next_byte = 8'h00;
    case (state)
      ST_DATA: next_byte = prefetch;
      ST_ID:   next_byte = jedec_byte(JEDEC_ID, id_idx);
      default: next_byte = 8'h00;
    endcase
  end

  // Busy follows the synchronized chip select, framed by its edge pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_busy <= 1'b0;
    end else if (cs_fall) begin
      o_busy <= 1'b1;
    end else if (cs_rise) begin
      o_busy <= 1'b0;
    end
  end

  // Memory read data arrives one cycle after the strobe; park it for the
  // next byte boundary so a sclk fall always finds it ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pending <= 1'b0;
      prefetch   <= 8'h00;
    end else begin
      rd_pending <= o_mem_rd;
      if (rd_pending) begin
        prefetch <= i_mem_rdata;
      end
    end
  end

  // Main protocol FSM: command/address shifting, miso serialization, reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= 5'd0;
      cmd_shift  <= 7'd0;
      fast       <= 1'b0;
      tx_shift   <= 7'd0;
      id_idx     <= 2'd0;
      o_miso     <= 1'b0;
      o_mem_rd   <= 1'b0;
      o_mem_addr <= '0;
      o_bad_cmd  <= 1'b0;
    end else begin
      o_mem_rd  <= 1'b0;
      o_bad_cmd <= 1'b0;

      if (cs_rise) begin
        // abort anywhere, partial bits are simply dropped
        state   <= ST_IDLE;
        bit_cnt <= 5'd0;
        o_miso  <= 1'b0;
        fast    <= 1'b0;
        id_idx  <= 2'd0;
      end else if (cs_fall) begin
        // a sclk edge landing in the same cycle is deliberately ignored
        state     <= ST_CMD;
        bit_cnt   <= 5'd0;
        cmd_shift <= 7'd0;
        o_miso    <= 1'b0;
        fast      <= 1'b0;
        id_idx    <= 2'd0;
      end else begin
        case (state)
          ST_CMD: begin
            if (sclk_rise) begin
              cmd_shift <= opcode[6:0];
              if (bit_cnt == 5'd7) begin
                bit_cnt <= 5'd0;
                case (opcode)
                  CMD_READ:      state <= ST_ADDR;
                  CMD_FAST_READ: begin
                    state <= ST_ADDR;
                    fast  <= 1'b1;
                  end
                  CMD_RDID:      state <= ST_ID;
                  CMD_RDSR:      state <= ST_STAT;
                  default: begin
                    state     <= ST_IGNORE;
                    o_bad_cmd <= 1'b1;
                  end
                endcase
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          ST_ADDR: begin
            if (sclk_rise) begin
              // bits above MEM_AW fall off the top of the register
              o_mem_addr <= {o_mem_addr[MEM_AW-2:0], mosi_s};
              if (bit_cnt == 5'd23) begin
                bit_cnt <= 5'd0;
                if (fast) begin
                  state <= ST_DUMMY;
                end else begin
                  state    <= ST_DATA;
                  o_mem_rd <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          ST_DUMMY: begin
            if (sclk_rise) begin
              if (bit_cnt == DUMMY_LAST) begin
                bit_cnt  <= 5'd0;
                state    <= ST_DATA;
                o_mem_rd <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          ST_DATA, ST_ID, ST_STAT: begin
            if (sclk_fall) begin
              if (bit_cnt == 5'd0) begin
                o_miso   <= next_byte[7];
                tx_shift <= next_byte[6:0];
                if (state == ST_ID && id_idx != 2'd3) begin
                  id_idx <= id_idx + 2'd1;
                end
              end else begin
                o_miso   <= tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
              end
            end
            if (sclk_rise) begin
              if (bit_cnt == 5'd7) begin
                bit_cnt <= 5'd0;
                if (state == ST_DATA) begin
                  // address and strobe change together, so the address is
                  // already stable for the whole strobe cycle
                  o_mem_addr <= o_mem_addr + ADDR_INC;
                  o_mem_rd   <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          ST_IGNORE: begin
            o_miso <= 1'b0;
          end

          default: begin
            o_miso <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
Synthesizable SPI-flash slave: the device end of the SoC flash port (o_flash_sclk/o_flash_cs_n/o_flash_mosi -> i_flash_miso). It lets the SoC boot/read path run in simulation and on FPGA without a real flash part. It oversamples the master's SPI mode-0 signals with the system clock, decodes a subset of standard flash commands, and serves read data from an external byte-wide memory port.

Parameters:
MEM_AW, 17, byte address width of backing memory (128 KB); upper received address bits ignored
JEDEC_ID, 24'hEF4017, value returned by READ ID, MSB byte first
SYNC_STAGES, 2, synchronizer flops on sclk/cs_n/mosi (min 2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
i_sclk  in  1  SPI clock from master (connects to o_flash_sclk)
i_cs_n  in  1  chip select, active low (connects to o_flash_cs_n)
i_mosi  in  1  master-out data (connects to o_flash_mosi)
o_miso  out  1  slave-out data (connects to i_flash_miso)
o_mem_rd  out  1  one-cycle read strobe to backing memory
o_mem_addr  out  MEM_AW  byte address for o_mem_rd
i_mem_rdata  in  8  read data, valid exactly 1 clk after o_mem_rd
o_busy  out  1  high while synchronized cs_n is low
o_bad_cmd  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters/shift regs 0.
- Timing contract: sclk high and low phases each >= 4 clk; cs_n setup/hold to sclk >= 4 clk. Slower sclk always legal.
- Inputs pass through SYNC_STAGES flops, then edge detect; rise/fall/cs_fall/cs_rise are single-cycle pulses.
- SPI mode 0: mosi sampled on sclk rise, MSB first; o_miso updated on sclk fall only.
- States: IDLE, CMD, ADDR, DUMMY, DATA, ID, STAT, IGNORE.
- IDLE -> CMD on cs_fall; bit counter cleared.
- CMD: shift 8 bits; on 8th rise decode: 0x03 -> ADDR; 0x0B -> ADDR (fast flag set); 0x9F -> ID; 0x05 -> STAT; other -> IGNORE, o_bad_cmd pulses the cycle after the 8th rise.
- ADDR: shift 24 bits; on 24th rise keep addr[MEM_AW-1:0]. Normal read: assert o_mem_rd that cycle, then DATA. Fast read: DUMMY.
- DUMMY: count 8 rises, ignore mosi; on 8th rise assert o_mem_rd, then DATA.
- DATA: i_mem_rdata captured 1 clk after o_mem_rd into prefetch reg. Each fall loads the next miso bit: the prefetch byte MSB at a byte boundary, else the next shift-reg bit. On each byte's 8th rise: address increments mod 2^MEM_AW, o_mem_rd asserts for the next byte. Bytes stream indefinitely.
- ID: returns JEDEC_ID[23:16], [15:8], [7:0], then 0x00 thereafter.
- STAT: returns 0x00 repeatedly (never busy, WEL=0).
- IGNORE: o_miso=0 until cs_rise.
- o_miso is 0 during CMD/ADDR/DUMMY and in IGNORE/IDLE.
- Boundaries:
  - cs_rise in any state, including mid-byte: abort to IDLE next cycle, o_miso=0, partial bits discarded, no further o_mem_rd.
  - cs_fall and sclk edge in the same cycle: cs_fall processed first, edge ignored.
  - Address 2^MEM_AW-1 wraps to 0.
  - Async reset mid-transaction: immediate return to reset values.
- o_mem_rd never asserts twice within 2 clk; o_mem_addr is held stable while o_mem_rd is high.

Decomposition:
- Package spi_flash_pkg: opcode localparams (CMD_READ=8'h03, CMD_FAST_READ=8'h0B, CMD_RDID=8'h9F, CMD_RDSR=8'h05), state enum spi_flash_state_t, DUMMY_CYCLES=8.
- Sub-module spi_sync_edge: parameterized SYNC_STAGES synchronizer plus rise/fall pulse generation, instantiated for sclk and cs_n; mosi uses the synchronizer only.
- Responder top holds FSM, counters, shift/prefetch regs.

Test Plan:
- mem[0x10]=A5, mem[0x11]=3C; send 03 00 00 10 then 16 clocks -> miso bytes A5, 3C; o_mem_rd at 0x10, 0x11, 0x12.
- Send 9F then 32 clocks -> miso EF, 40, 17, 00; no o_mem_rd.
- mem[0x100]=5A; send 0B 00 01 00 + 8 dummy clocks + 8 clocks -> miso 5A; miso=0 during dummy.
- mem[0x1FFFF]=11, mem[0]=22; READ at FF FF FF -> miso 11, 22 (upper bits ignored, wrap to 0).
- Send AB -> o_bad_cmd single pulse, miso=0 for 16 further clocks; then cs high/low, 05 + 8 clocks -> 00.
- READ at 0x10, raise cs_n after 3 data bits -> FSM IDLE, miso=0; new READ at 0x11 returns 3C correctly.
